alu_seq: RTL and testbench

- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Keeps the existing ALUCtrl encodings and adds an iterative multiply.
- Produces full NZCV flags and registers all outputs behind valid/ready on both sides.
- Sits between the decode/register-read stage and writeback of the pipelined processor; a stalled consumer back-pressures issue cleanly.

---
 rtl/alu_seq.sv | 137 +++++++++++++
 tb/tb_alu_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU with registered NZCV flags and an iterative shift-add multiply.
// Single-cycle ops finish on the accept edge; MUL takes WIDTH further cycles.
module alu_seq #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'h0,
    OP_ORR  = 4'h1,
    OP_ADD  = 4'h2,
    OP_LSR  = 4'h3,
    OP_LSL  = 4'h4,
    OP_SUB  = 4'h6,
    OP_PASS = 4'h7,
    OP_MUL  = 4'h8
  } opcode_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_step;
  logic [SHW-1:0]   cnt;
  logic             last_iter, accept, is_mul;

  logic [WIDTH:0]   sum_add, sum_sub;
  logic [WIDTH-1:0] res;
  logic             res_c, res_v;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (ALUCtrl == OP_MUL);
  assign last_iter = (cnt == SHW'(WIDTH - 1));
  assign acc_step  = acc + (mcand[cnt] ? (mplier << cnt) : '0);

  always_comb begin
    sum_add = {1'b0, BusA} + {1'b0, BusB};
    sum_sub = {1'b0, BusA} + {1'b0, ~BusB} + (WIDTH+1)'(1);
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    case (ALUCtrl)
      OP_AND:  res = BusA & BusB;
      OP_ORR:  res = BusA | BusB;
      OP_ADD: begin
        res   = sum_add[WIDTH-1:0];
        res_c = sum_add[WIDTH];
        res_v = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (res[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_LSR:  res = BusA >> BusB[SHW-1:0];
      OP_LSL:  res = BusA << BusB[SHW-1:0];
      OP_SUB: begin
        // Carry is the adder carry-out of A+~B+1, i.e. NOT borrow.
        res   = sum_sub[WIDTH-1:0];
        res_c = sum_sub[WIDTH];
        res_v = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (res[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_PASS: res = BusB;
      default: res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = is_mul ? MUL : DONE;
      MUL:  if (last_iter) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      BusW     <= '0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mcand  <= BusA;
          mplier <= BusB;
          acc    <= '0;
          cnt    <= '0;
          if (!is_mul) begin
            BusW     <= res;
            Zero     <= (res == '0);
            Negative <= res[WIDTH-1];
            Carry    <= res_c;
            Overflow <= res_v;
          end
        end
        MUL: begin
          acc <= acc_step;
          cnt <= cnt + SHW'(1);
          if (last_iter) begin
            BusW     <= acc_step;
            Zero     <= (acc_step == '0);
            Negative <= acc_step[WIDTH-1];
            Carry    <= 1'b0;
            Overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=64 and WIDTH=8; flags packed as {N,Z,C,V}.
module tb_alu_seq;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] w;
    logic [3:0]  f;
  } exp_t;

  exp_t q64[$];
  exp_t q8[$];
  exp_t e64, e8;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  logic        rst64 = 1'b0, iv64 = 1'b0, ordy64 = 1'b1;
  logic [63:0] a64 = '0, b64 = '0;
  logic [3:0]  op64 = '0;
  logic        rdy64, ov64, z64, n64, c64, v64;
  logic [63:0] w64;

  logic        rst8 = 1'b0, iv8 = 1'b0, ordy8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  op8 = '0;
  logic        rdy8, ov8, z8, n8, c8, v8;
  logic [7:0]  w8;

  alu_seq #(.WIDTH(64)) dut64 (
    .CLK(CLK), .Reset_L(rst64), .in_valid(iv64), .in_ready(rdy64),
    .BusA(a64), .BusB(b64), .ALUCtrl(op64), .out_valid(ov64), .out_ready(ordy64),
    .BusW(w64), .Zero(z64), .Negative(n64), .Carry(c64), .Overflow(v64)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .CLK(CLK), .Reset_L(rst8), .in_valid(iv8), .in_ready(rdy8),
    .BusA(a8), .BusB(b8), .ALUCtrl(op8), .out_valid(ov8), .out_ready(ordy8),
    .BusW(w8), .Zero(z8), .Negative(n8), .Carry(c8), .Overflow(v8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (ov64 && ordy64) begin
      if (q64.size() == 0) begin
        checks++; fails++;
        $display("FAIL w64_unexpected: got result %h, expected none", w64);
      end else begin
        e64 = q64.pop_front();
        chk("w64_busw", w64, e64.w);
        chk("w64_flags", {60'd0, n64, z64, c64, v64}, {60'd0, e64.f});
      end
    end
  end

  always @(negedge CLK) begin
    if (ov8 && ordy8) begin
      if (q8.size() == 0) begin
        checks++; fails++;
        $display("FAIL w8_unexpected: got result %h, expected none", w8);
      end else begin
        e8 = q8.pop_front();
        chk("w8_busw", {56'd0, w8}, e8.w);
        chk("w8_flags", {60'd0, n8, z8, c8, v8}, {60'd0, e8.f});
      end
    end
  end

  // Called just after a posedge; returns just after a posedge.
  task automatic issue64(input string nm, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] ew, input logic [3:0] ef,
                         input int elat, input bit track);
    int k, lat, busy;
    exp_t e;
    k = 0;
    while (!rdy64 && k < 200) begin @(posedge CLK); #1; k++; end
    chk({nm, "_ready"}, {63'd0, rdy64}, 64'd1);
    e.w = ew; e.f = ef;
    q64.push_back(e);
    iv64 = 1'b1; a64 = a; b64 = b; op64 = op;
    @(posedge CLK); #1;
    iv64 = 1'b0; a64 = '1; b64 = '1; op64 = 4'h2;
    if (track) begin
      lat = 0; busy = 0;
      for (int i = 1; i <= 200; i++) begin
        if (ov64 && lat == 0) lat = i;
        if (rdy64) break;
        busy++;
        @(posedge CLK); #1;
      end
      chk({nm, "_lat"}, 64'(lat), 64'(elat));
      chk({nm, "_busy"}, 64'(busy), 64'(elat));
    end
  endtask

  task automatic issue8(input string nm, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] ew, input logic [3:0] ef,
                        input int elat);
    int k, lat, busy;
    exp_t e;
    k = 0;
    while (!rdy8 && k < 200) begin @(posedge CLK); #1; k++; end
    chk({nm, "_ready"}, {63'd0, rdy8}, 64'd1);
    e.w = {56'd0, ew}; e.f = ef;
    q8.push_back(e);
    iv8 = 1'b1; a8 = a; b8 = b; op8 = op;
    @(posedge CLK); #1;
    iv8 = 1'b0; a8 = '1; b8 = '1; op8 = 4'h2;
    lat = 0; busy = 0;
    for (int i = 1; i <= 200; i++) begin
      if (ov8 && lat == 0) lat = i;
      if (rdy8) break;
      busy++;
      @(posedge CLK); #1;
    end
    chk({nm, "_lat"}, 64'(lat), 64'(elat));
    chk({nm, "_busy"}, 64'(busy), 64'(elat));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    #3;
    chk("rst_in_ready", {63'd0, rdy64}, 64'd1);
    chk("rst_out_valid", {63'd0, ov64}, 64'd0);
    chk("rst_busw", w64, 64'd0);
    chk("rst_flags", {60'd0, n64, z64, c64, v64}, 64'd0);
    chk("rst8_busw", {56'd0, w8}, 64'd0);
    @(negedge CLK);
    rst64 = 1'b1; rst8 = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("idle_out_valid", {63'd0, ov64}, 64'd0);

    issue64("add_wrap", 4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110, 1, 1);
    issue64("add_ovf", 4'h2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001, 1, 1);
    issue64("sub_neg", 4'h6, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1, 1);
    issue64("sub_pos", 4'h6, 64'd7, 64'd5, 64'd2, 4'b0010, 1, 1);
    issue64("mul_3x5", 4'h8, 64'd3, 64'd5, 64'd15, 4'b0000, 65, 1);
    issue64("mul_trunc", 4'h8, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 4'b0100, 65, 1);
    issue64("and", 4'h0, 64'hF0F0, 64'hFF00, 64'hF000, 4'b0000, 1, 1);
    issue64("lsr_max", 4'h3, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 4'b0000, 1, 1);
    issue64("lsr_zero", 4'h3, 64'h1234, 64'd64, 64'h1234, 4'b0000, 1, 1);
    issue64("pass", 4'h7, 64'hDEAD, 64'd0, 64'd0, 4'b0100, 1, 1);
    issue64("undef", 4'h5, 64'd1, 64'd2, 64'd0, 4'b0100, 1, 1);

    ordy64 = 1'b0;
    issue64("lsl_bp", 4'h4, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 4'b1000, 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {63'd0, ov64}, 64'd1);
      chk("bp_in_ready", {63'd0, rdy64}, 64'd0);
      chk("bp_busw", w64, 64'h8000_0000_0000_0000);
      @(posedge CLK); #1;
    end
    ordy64 = 1'b1;
    chk("bp_ready_hold", {63'd0, rdy64}, 64'd0);
    @(posedge CLK); #1;
    chk("bp_ready_rise", {63'd0, rdy64}, 64'd1);

    issue64("mul_abort", 4'h8, 64'd3, 64'd5, 64'd15, 4'b0000, 65, 0);
    repeat (9) @(posedge CLK);
    #2 rst64 = 1'b0;
    #1;
    chk("abort_out_valid", {63'd0, ov64}, 64'd0);
    chk("abort_in_ready", {63'd0, rdy64}, 64'd1);
    chk("abort_busw", w64, 64'd0);
    q64.delete();
    #2 rst64 = 1'b1;
    seen = 0;
    repeat (70) begin
      @(posedge CLK); #1;
      if (ov64) seen++;
    end
    chk("abort_no_stale", 64'(seen), 64'd0);
    issue64("orr", 4'h1, 64'd2, 64'd1, 64'd3, 4'b0000, 1, 1);

    issue8("w8_add_wrap", 4'h2, 8'hFF, 8'h01, 8'h00, 4'b0110, 1);
    issue8("w8_add_ovf", 4'h2, 8'h7F, 8'h01, 8'h80, 4'b1001, 1);
    issue8("w8_sub_neg", 4'h6, 8'd5, 8'd7, 8'hFE, 4'b1000, 1);
    issue8("w8_sub_pos", 4'h6, 8'd7, 8'd5, 8'h02, 4'b0010, 1);
    issue8("w8_mul_15x17", 4'h8, 8'd15, 8'd17, 8'hFF, 4'b1000, 9);
    issue8("w8_mul_3x5", 4'h8, 8'd3, 8'd5, 8'h0F, 4'b0000, 9);
    issue8("w8_mul_trunc", 4'h8, 8'h10, 8'h10, 8'h00, 4'b0100, 9);
    issue8("w8_lsl_max", 4'h4, 8'd1, 8'd7, 8'h80, 4'b1000, 1);
    issue8("w8_lsl_zero", 4'h4, 8'd1, 8'd8, 8'h01, 4'b0000, 1);

    repeat (3) @(posedge CLK);
    #1;
    chk("q64_drained", 64'(q64.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
